// File: rtl/serial_sub8_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub8_pkg;

   // Default operand width; the result carries one extra bit for the borrow.
   localparam int W_DEFAULT = 8;

   // Sequencer states; encodings are fixed so other blocks can decode them.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage : serial_sub8_pkg

// File: rtl/serial_sub8_full_sub1.sv
// One-bit full subtractor: diff = a - b - bin, bout = borrow out.
module full_sub1 (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic diff,
   output logic bout
);

   // Borrow is raised when b exceeds a, or when they are equal and a borrow came in.
   always_comb begin
      diff = a ^ b ^ bin;
      bout = (~a & b) | (~(a ^ b) & bin);
   end

endmodule : full_sub1

// File: rtl/serial_sub8.sv
// Bit-serial W-bit subtractor d = x - y, one bit per clock, LSB first,
// with a start/done handshake. d[W] is the final borrow (x < y unsigned).
module serial_sub8
   import serial_sub8_pkg::*;
#(
   parameter int W = W_DEFAULT
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   output logic         busy,
   output logic         done,
   output logic [W:0]   d
);

   localparam int CW = (W > 1) ? $clog2(W) : 1;

   state_t        state_q, state_d;
   logic [W-1:0]  xs_q;
   logic [W-1:0]  ys_q;
   logic [W-1:0]  res_q;
   logic          b_q;
   logic [CW-1:0] cnt_q;
   logic [W:0]    d_q;

   logic          diff_w;
   logic          bout_w;
   logic          last_bit;

   // The counter holds the index of the bit being processed this cycle.
   assign last_bit = (cnt_q == CW'(W - 1));

   full_sub1 u_full_sub1 (
      .a    (xs_q[0]),
      .b    (ys_q[0]),
      .bin  (b_q),
      .diff (diff_w),
      .bout (bout_w)
   );

   // State register; reset drops straight back to IDLE without a clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: start is only honoured in IDLE, DONE lasts one cycle.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (start)    state_d = ST_RUN;
         ST_RUN:  if (last_bit) state_d = ST_DONE;
         ST_DONE:               state_d = ST_IDLE;
         default:               state_d = ST_IDLE;
      endcase
   end

   // Output decode: busy covers RUN and DONE, done flags the DONE cycle.
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      unique case (state_q)
         ST_IDLE: ;
         ST_RUN:  busy = 1'b1;
         ST_DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: ;
      endcase
   end

   // Datapath: capture operands on accept, then shift one bit per RUN cycle;
   // d is only written on the last bit so it holds across later RUNs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xs_q  <= '0;
         ys_q  <= '0;
         res_q <= '0;
         b_q   <= 1'b0;
         cnt_q <= '0;
         d_q   <= '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (start) begin
                  xs_q  <= x;
                  ys_q  <= y;
                  res_q <= '0;
                  b_q   <= 1'b0;
                  cnt_q <= '0;
               end
            end
            ST_RUN: begin
               res_q <= {diff_w, res_q[W-1:1]};
               xs_q  <= {1'b0, xs_q[W-1:1]};
               ys_q  <= {1'b0, ys_q[W-1:1]};
               b_q   <= bout_w;
               cnt_q <= cnt_q + CW'(1);
               if (last_bit) begin
                  d_q <= {bout_w, diff_w, res_q[W-1:1]};
               end
            end
            default: ;
         endcase
      end
   end

   assign d = d_q;

endmodule : serial_sub8

// File: tb/tb_serial_sub8.sv
// Scoreboard bench for serial_sub8: stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_serial_sub8;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] x;
   logic [7:0] y;
   logic       busy;
   logic       done;
   logic [8:0] d;

   logic [8:0] exp_q[$];

   int         tests;
   int         fails;
   logic [8:0] hold_exp;
   logic [8:0] exp_v;
   int         lat;
   bit         after_done;
   bit         end_req;
   bit         end_ack;

   localparam logic [7:0] AA [16] = '{8'h00, 8'h01, 8'h0F, 8'h10, 8'h7F, 8'h80, 8'h55, 8'hAA,
                                      8'h12, 8'h3C, 8'h00, 8'hFE, 8'h01, 8'h40, 8'h99, 8'h23};
   localparam logic [7:0] BB [16] = '{8'h00, 8'h01, 8'h01, 8'h0F, 8'h80, 8'h7F, 8'hAA, 8'h55,
                                      8'h34, 8'hC3, 8'hFF, 8'h01, 8'hFE, 8'h40, 8'h66, 8'h45};

   serial_sub8 #(.W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .x     (x),
      .y     (y),
      .busy  (busy),
      .done  (done),
      .d     (d)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: reset state, latency, scoreboard pop on done, d stability otherwise.
   always @(negedge clk) begin
      if (!rst_n) begin
         tests++;
         if (busy !== 1'b0 || done !== 1'b0 || d !== 9'h000) begin
            fails++;
            $display("FAIL reset_state: busy=%b done=%b d=%h, required busy=0 done=0 d=000", busy, done, d);
         end
         hold_exp   = 9'h000;
         lat        = 0;
         after_done = 1'b0;
      end else begin
         if (after_done) begin
            tests++;
            if (busy !== 1'b0) begin
               fails++;
               $display("FAIL busy_after_done: busy=%b, required 0", busy);
            end
         end
         after_done = (done === 1'b1);
         if (busy === 1'b1) lat++;
         else lat = 0;
         if (done === 1'b1) begin
            tests++;
            if (lat != 9) begin
               fails++;
               $display("FAIL latency: done after %0d edges from accept, required 9", lat);
            end
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_done: d=%h with no operation pending", d);
            end else begin
               exp_v = exp_q.pop_front();
               if (d !== exp_v) begin
                  fails++;
                  $display("FAIL result: d=%h, required %h", d, exp_v);
               end
               hold_exp = exp_v;
            end
         end else begin
            tests++;
            if (d !== hold_exp) begin
               fails++;
               $display("FAIL d_hold: d=%h, required %h", d, hold_exp);
            end
         end
         if (end_req && !end_ack) begin
            tests++;
            if (exp_q.size() != 0) begin
               fails++;
               $display("FAIL missing_done: %0d results outstanding, required 0", exp_q.size());
            end
            end_ack = 1'b1;
         end
      end
   end

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy !== 1'b0 && n < 100) begin
         @(negedge clk);
         n++;
      end
   endtask

   // Present one start pulse when idle; optionally record the expected result.
   task automatic issue(input logic [7:0] xv, input logic [7:0] yv,
                        input logic [8:0] expv, input bit push);
      wait_idle();
      x     = xv;
      y     = yv;
      start = 1'b1;
      if (push) exp_q.push_back(expv);
      $display("[TB] start x=%h y=%h expect=%h%s", xv, yv, expv, push ? "" : " (to be aborted)");
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      logic [7:0] hx [11];
      logic [7:0] hy [11];
      logic [7:0] rx;
      logic [7:0] ry;
      int         n;

      start   = 1'b0;
      x       = '0;
      y       = '0;
      end_req = 1'b0;
      rst_n   = 1'b1;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed basic cases.
      issue(8'd5,   8'd3,   9'h002, 1'b1);
      issue(8'd0,   8'd1,   9'h1FF, 1'b1);
      issue(8'd255, 8'd128, 9'h07F, 1'b1);

      // Adder pairs in reverse: (a + b) - b must give back a with no borrow.
      for (int i = 0; i < 16; i++) begin
         issue(AA[i] + BB[i], BB[i], {1'b0, AA[i]}, 1'b1);
      end

      // start held high with changing operands: only edges 1 and 11 accept.
      for (int i = 0; i < 11; i++) begin
         hx[i] = 8'(i * 37 + 3);
         hy[i] = 8'(i * 19 + 91);
      end
      hx[0]  = 8'h40;
      hy[0]  = 8'h11;
      hx[10] = 8'h10;
      hy[10] = 8'h20;
      wait_idle();
      exp_q.push_back(9'h02F);
      exp_q.push_back(9'h1F0);
      for (int i = 0; i < 11; i++) begin
         x     = hx[i];
         y     = hy[i];
         start = 1'b1;
         $display("[TB] held start x=%h y=%h", hx[i], hy[i]);
         @(negedge clk);
      end
      start = 1'b0;

      // Abort an operation after four bits with a half-cycle reset pulse.
      issue(8'hAA, 8'h55, 9'h055, 1'b0);
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #5 rst_n = 1'b1;
      $display("[TB] mid-run reset pulse applied");
      repeat (15) @(negedge clk);
      issue(8'd200, 8'd55, 9'h091, 1'b1);

      // Zero result followed by wrap-around; d must hold between the dones.
      issue(8'd128, 8'd128, 9'h000, 1'b1);
      issue(8'd0,   8'd255, 9'h101, 1'b1);

      // Random sweep against a reference difference.
      for (int i = 0; i < 256; i++) begin
         rx = 8'($urandom_range(0, 255));
         ry = 8'($urandom_range(0, 255));
         issue(rx, ry, {1'b0, rx} - {1'b0, ry}, 1'b1);
      end

      wait_idle();
      repeat (3) @(negedge clk);
      end_req = 1'b1;
      n = 0;
      while (!end_ack && n < 10) begin
         @(negedge clk);
         n++;
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_serial_sub8
